// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing generator with registered addresses/syncs
// and one-cycle-late pixel capture from the renderer.
module vga_scan_ctrl #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_SYNC   = 96,
  parameter int V_SYNC   = 2,
  parameter int H_START  = 143,
  parameter int V_START  = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [11:0] d_in_BGR,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        rdn,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        frame_done
);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW    = 10'(H_SYNC);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);
  localparam logic [9:0] H_FIRST = 10'(H_START);
  localparam logic [9:0] V_FIRST = 10'(V_START);
  localparam logic [9:0] H_STOP  = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_STOP  = 10'(V_START + V_ACTIVE);
  logic [9:0] h_count, v_count, row_diff;
  logic h_end, v_end, visible;
  always_comb begin
    h_end    = h_count == H_LAST;
    v_end    = v_count == V_LAST;
    visible  = h_count >= H_FIRST && h_count < H_STOP && v_count >= V_FIRST && v_count < V_STOP;
    row_diff = v_count - V_FIRST;
  end
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      h_count    <= '0;
      v_count    <= '0;
      row_addr   <= '0;
      col_addr   <= '0;
      rdn        <= 1'b1;
      hs         <= 1'b1;
      vs         <= 1'b1;
      {b, g, r}  <= 12'h000;
      frame_done <= 1'b0;
    end else begin
      h_count    <= h_end ? 10'd0 : h_count + 10'd1;
      if (h_end) v_count <= v_end ? 10'd0 : v_count + 10'd1;
      col_addr   <= h_count - H_FIRST;
      row_addr   <= row_diff[8:0];
      rdn        <= ~visible;
      hs         <= h_count >= H_SW;
      vs         <= v_count >= V_SW;
      // rdn here is still the previous registered value, i.e. the address the renderer just served
      {b, g, r}  <= rdn ? 12'h000 : d_in_BGR;
      frame_done <= h_end && v_end;
    end
  end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: randomized bench comparing the scan controller against a
// pixel-index reference model, using a reduced raster to keep frames short.
module tb_vga_scan_ctrl;
  localparam int HT = 40, VT = 20, HS = 5, VS = 2, HST = 8, VST = 3, HA = 24, VA = 12;
  localparam int FR = HT * VT;
  logic vga_clk = 1'b0;
  logic clrn = 1'b0;
  logic [11:0] d_in_BGR = 12'h000;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic rdn, hs, vs, frame_done;
  logic [3:0] r, g, b;
  int checks = 0, failures = 0;
  int n = 0;
  logic [11:0] last_d = 12'h000;

  vga_scan_ctrl #(.H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS), .H_START(HST),
                  .V_START(VST), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .d_in_BGR(d_in_BGR), .row_addr(row_addr),
    .col_addr(col_addr), .rdn(rdn), .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
    .frame_done(frame_done));

  always #5 vga_clk = ~vga_clk;

  // Model: after n edges since reset the registered outputs describe raster index n-1.
  function automatic int hp(int p); return p % HT; endfunction
  function automatic int vp(int p); return (p / HT) % VT; endfunction
  function automatic logic vis(int p);
    return hp(p) >= HST && hp(p) < HST + HA && vp(p) >= VST && vp(p) < VST + VA;
  endfunction

  task automatic step(input logic rn, input logic [11:0] d);
    clrn = rn;
    d_in_BGR = d;
    @(posedge vga_clk);
    #1;
    last_d = d;
    n = rn ? n + 1 : 0;
  endtask

  task automatic run_to(input int target);
    while (n < target) step(1'b1, 12'($urandom));
  endtask

  task automatic test_reset;
    step(1'b0, 12'hFFF);
    step(1'b0, 12'($urandom));
    checks += 6;
    if (row_addr !== 9'd0)  begin failures++; $display("FAIL reset_row got %0d exp 0", row_addr); end
    if (col_addr !== 10'd0) begin failures++; $display("FAIL reset_col got %0d exp 0", col_addr); end
    if ({rdn, hs, vs} !== 3'b111) begin failures++; $display("FAIL reset_strobes got %b exp 111", {rdn, hs, vs}); end
    if ({b, g, r} !== 12'h000) begin failures++; $display("FAIL reset_rgb got %h exp 000", {b, g, r}); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    if (dut.h_count !== 10'd0 || dut.v_count !== 10'd0) begin
      failures++; $display("FAIL reset_counters got %0d,%0d exp 0,0", dut.h_count, dut.v_count);
    end
  endtask

  task automatic test_scan;
    int p;
    logic [11:0] exp_rgb;
    step(1'b0, 12'h000);
    for (int i = 0; i < 2 * FR + 5; i++) begin
      step(1'b1, 12'($urandom));
      p = n - 1;
      exp_rgb = (n >= 2 && vis(n - 2)) ? last_d : 12'h000;
      checks += 7;
      if (col_addr !== 10'((hp(p) - HST) & 1023)) begin failures++; $display("FAIL scan_col n=%0d got %0d exp %0d", n, col_addr, (hp(p) - HST) & 1023); end
      if (row_addr !== 9'((vp(p) - VST) & 511)) begin failures++; $display("FAIL scan_row n=%0d got %0d exp %0d", n, row_addr, (vp(p) - VST) & 511); end
      if (rdn !== !vis(p)) begin failures++; $display("FAIL scan_rdn n=%0d got %b exp %b", n, rdn, !vis(p)); end
      if (hs !== (hp(p) >= HS)) begin failures++; $display("FAIL scan_hs n=%0d got %b exp %b", n, hs, hp(p) >= HS); end
      if (vs !== (vp(p) >= VS)) begin failures++; $display("FAIL scan_vs n=%0d got %b exp %b", n, vs, vp(p) >= VS); end
      if ({b, g, r} !== exp_rgb) begin failures++; $display("FAIL scan_rgb n=%0d got %h exp %h", n, {b, g, r}, exp_rgb); end
      if (frame_done !== (p % FR == FR - 1)) begin failures++; $display("FAIL scan_frame_done n=%0d got %b exp %b", n, frame_done, p % FR == FR - 1); end
    end
  endtask

  task automatic test_sync;
    int hs_low = 0, vs_low = 0, last_fall = -1, bad_period = 0;
    logic prev_hs;
    step(1'b0, 12'h000);
    step(1'b1, 12'h000);
    checks++;
    if (hs !== 1'b0) begin failures++; $display("FAIL sync_first_fall got %b exp 0", hs); end
    prev_hs = 1'b1;
    for (int i = 0; i < FR; i++) begin
      if (!hs) hs_low++;
      if (!vs) vs_low++;
      if (prev_hs && !hs) begin
        if (last_fall >= 0 && n - last_fall != HT) bad_period++;
        last_fall = n;
      end
      prev_hs = hs;
      step(1'b1, 12'($urandom));
    end
    checks += 3;
    if (hs_low !== HS * VT) begin failures++; $display("FAIL sync_hs_low got %0d exp %0d", hs_low, HS * VT); end
    if (vs_low !== VS * HT) begin failures++; $display("FAIL sync_vs_low got %0d exp %0d", vs_low, VS * HT); end
    if (bad_period !== 0) begin failures++; $display("FAIL sync_hs_period got %0d bad exp 0", bad_period); end
  endtask

  task automatic test_first_visible;
    int p0 = VST * HT + HST;
    step(1'b0, 12'h000);
    run_to(p0 + 1);
    checks += 2;
    if ({rdn, row_addr, col_addr} !== {1'b0, 9'd0, 10'd0}) begin
      failures++; $display("FAIL first_vis_addr got rdn=%b row=%0d col=%0d exp 0,0,0", rdn, row_addr, col_addr);
    end
    step(1'b1, 12'hF0A);
    if ({r, g, b} !== 12'hA0F) begin failures++; $display("FAIL first_vis_rgb got r=%h g=%h b=%h exp A,0,F", r, g, b); end
  endtask

  task automatic test_last_visible;
    int pl = (VST + VA - 1) * HT + HST + HA - 1;
    step(1'b0, 12'h000);
    run_to(pl + 1);
    checks += 4;
    if ({rdn, row_addr, col_addr} !== {1'b0, 9'(VA - 1), 10'(HA - 1)}) begin
      failures++; $display("FAIL last_vis_addr got rdn=%b row=%0d col=%0d exp 0,%0d,%0d", rdn, row_addr, col_addr, VA - 1, HA - 1);
    end
    step(1'b1, 12'hFFF);
    if (rdn !== 1'b1) begin failures++; $display("FAIL last_vis_rdn_after got %b exp 1", rdn); end
    if ({b, g, r} !== 12'hFFF) begin failures++; $display("FAIL last_vis_rgb got %h exp FFF", {b, g, r}); end
    step(1'b1, 12'hFFF);
    if ({b, g, r} !== 12'h000) begin failures++; $display("FAIL last_vis_blank got %h exp 000", {b, g, r}); end
  endtask

  task automatic test_frame_done;
    int pulses = 0, misplaced = 0;
    step(1'b0, 12'h000);
    for (int i = 0; i < 2 * FR + 3; i++) begin
      step(1'b1, 12'($urandom));
      if (frame_done) begin
        pulses++;
        if (n % FR != 0) misplaced++;
      end
    end
    checks += 2;
    if (pulses !== 2) begin failures++; $display("FAIL frame_done_count got %0d exp 2", pulses); end
    if (misplaced !== 0) begin failures++; $display("FAIL frame_done_place got %0d bad exp 0", misplaced); end
  endtask

  task automatic test_blanking;
    int nonzero = 0;
    step(1'b0, 12'hFFF);
    for (int i = 0; i < FR; i++) begin
      step(1'b1, 12'hFFF);
      if ({b, g, r} != 12'h000) nonzero++;
    end
    checks++;
    if (nonzero !== HA * VA) begin failures++; $display("FAIL blank_count got %0d exp %0d", nonzero, HA * VA); end
  endtask

  task automatic test_reset_mid;
    step(1'b0, 12'h000);
    run_to(10 * HT + 20);
    step(1'b0, 12'hFFF);
    checks += 4;
    if ({row_addr, col_addr, rdn, hs, vs, b, g, r, frame_done} !== {9'd0, 10'd0, 3'b111, 12'h000, 1'b0}) begin
      failures++; $display("FAIL mid_reset_outputs got row=%0d col=%0d strobes=%b rgb=%h fd=%b", row_addr, col_addr, {rdn, hs, vs}, {b, g, r}, frame_done);
    end
    if (dut.h_count !== 10'd0 || dut.v_count !== 10'd0) begin
      failures++; $display("FAIL mid_reset_counters got %0d,%0d exp 0,0", dut.h_count, dut.v_count);
    end
    step(1'b1, 12'hFFF);
    if (col_addr !== 10'((0 - HST) & 1023) || row_addr !== 9'((0 - VST) & 511)) begin
      failures++; $display("FAIL mid_reset_restart got row=%0d col=%0d exp %0d,%0d", row_addr, col_addr, (0 - VST) & 511, (0 - HST) & 1023);
    end
    step(1'b1, 12'hFFF);
    if (col_addr !== 10'((1 - HST) & 1023)) begin failures++; $display("FAIL mid_reset_advance got %0d exp %0d", col_addr, (1 - HST) & 1023); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_sync;
    test_first_visible;
    test_last_visible;
    test_frame_done;
    test_blanking;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
